// File: rtl/ex_stage.sv
// Execute stage: stall-aware decode-to-execute register, one-hot operand muxes and ALU,
// data-SRAM request generation, write-back forwarding and load-use hazard flag.
module ex_stage #(
  localparam int ID_TO_EX_WD  = 161,
  localparam int EX_TO_MEM_WD = 78,
  localparam int EX_TO_RF_WD  = 38,
  localparam int StallBus     = 6,
  localparam int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_load_hazard,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [DATA_W-1:0]       data_sram_addr,
  output logic [DATA_W-1:0]       data_sram_wdata
);

  logic [ID_TO_EX_WD-1:0] id_to_ex_bus_p1;

  // Stage boundary: decode -> execute register (bubble when ID holds but EX moves)
  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_bus_p1 <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_to_ex_bus_p1 <= '0;
    end else if (!stall[2]) begin
      id_to_ex_bus_p1 <= id_to_ex_bus;
    end
  end

  logic [1:0]        mem_op_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] inst_p1;
  logic [11:0]       alu_op_p1;
  logic [2:0]        sel_src1_p1;
  logic [3:0]        sel_src2_p1;
  logic              ram_en_p1;
  logic [3:0]        ram_wen_p1;
  logic              rf_we_p1;
  logic [4:0]        rf_waddr_p1;
  logic              sel_rf_res_p1;
  logic [DATA_W-1:0] rdata1_p1;
  logic [DATA_W-1:0] rdata2_p1;

  assign {mem_op_p1, pc_p1, inst_p1, alu_op_p1, sel_src1_p1, sel_src2_p1,
          ram_en_p1, ram_wen_p1, rf_we_p1, rf_waddr_p1, sel_rf_res_p1,
          rdata1_p1, rdata2_p1} = id_to_ex_bus_p1;

  logic unused_bits;
  assign unused_bits = ^{inst_p1[31:16], stall[5:4], stall[1:0]};

  logic        [DATA_W-1:0] src1_p1;
  logic        [DATA_W-1:0] src2_p1;
  logic signed [DATA_W-1:0] src1_s_p1;
  logic signed [DATA_W-1:0] src2_s_p1;

  // AND-OR muxes: an empty select yields a zero operand
  always_comb begin
    src1_p1 = ({DATA_W{sel_src1_p1[0]}} & rdata1_p1)
            | ({DATA_W{sel_src1_p1[1]}} & pc_p1)
            | ({DATA_W{sel_src1_p1[2]}} & {27'b0, inst_p1[10:6]});
    src2_p1 = ({DATA_W{sel_src2_p1[0]}} & rdata2_p1)
            | ({DATA_W{sel_src2_p1[1]}} & {{16{inst_p1[15]}}, inst_p1[15:0]})
            | ({DATA_W{sel_src2_p1[2]}} & 32'd8)
            | ({DATA_W{sel_src2_p1[3]}} & {16'b0, inst_p1[15:0]});
  end

  assign src1_s_p1 = src1_p1;
  assign src2_s_p1 = src2_p1;

  logic              op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
  logic              op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
  logic [DATA_W-1:0] ex_result_p1;

  assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
          op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = alu_op_p1;

  always_comb begin
    ex_result_p1 = '0;
    if (op_add)  ex_result_p1 = ex_result_p1 | (src1_p1 + src2_p1);
    if (op_sub)  ex_result_p1 = ex_result_p1 | (src1_p1 - src2_p1);
    if (op_slt)  ex_result_p1 = ex_result_p1 | {31'b0, (src1_s_p1 < src2_s_p1)};
    if (op_sltu) ex_result_p1 = ex_result_p1 | {31'b0, (src1_p1 < src2_p1)};
    if (op_and)  ex_result_p1 = ex_result_p1 | (src1_p1 & src2_p1);
    if (op_nor)  ex_result_p1 = ex_result_p1 | ~(src1_p1 | src2_p1);
    if (op_or)   ex_result_p1 = ex_result_p1 | (src1_p1 | src2_p1);
    if (op_xor)  ex_result_p1 = ex_result_p1 | (src1_p1 ^ src2_p1);
    if (op_sll)  ex_result_p1 = ex_result_p1 | (src2_p1 << src1_p1[4:0]);
    if (op_srl)  ex_result_p1 = ex_result_p1 | (src2_p1 >> src1_p1[4:0]);
    if (op_sra)  ex_result_p1 = ex_result_p1 | DATA_W'(src2_s_p1 >>> src1_p1[4:0]);
    if (op_lui)  ex_result_p1 = ex_result_p1 | {src2_p1[15:0], 16'b0};
  end

  // Only word stores exist, so any nonzero byte mask widens to all four lanes
  assign data_sram_en    = ram_en_p1;
  assign data_sram_wen   = (ram_en_p1 && (ram_wen_p1 != 4'b0)) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = ex_result_p1;
  assign data_sram_wdata = rdata2_p1;

  assign ex_to_mem_bus  = {mem_op_p1, pc_p1, ram_en_p1, ram_wen_p1, sel_rf_res_p1,
                           rf_we_p1, rf_waddr_p1, ex_result_p1};
  assign ex_to_rf_bus   = {rf_we_p1, rf_waddr_p1, ex_result_p1};
  assign ex_load_hazard = sel_rf_res_p1 & rf_we_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected output vectors are queued as packets are
// driven and popped one cycle later when the stage presents them.
module tb_ex_stage;

  localparam int OBS_W = 78 + 38 + 1 + 1 + 4 + 32 + 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [160:0] id_to_ex_bus;
  logic [77:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_load_hazard;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] e;
  logic [OBS_W-1:0] sb[$];
  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus),
    .ex_load_hazard(ex_load_hazard), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  assign obs = {ex_to_mem_bus, ex_to_rf_bus, ex_load_hazard, data_sram_en,
                data_sram_wen, data_sram_addr, data_sram_wdata};

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] AND = 12'h080, NOR = 12'h040, OR = 12'h020, XOR = 12'h010;
  localparam logic [11:0] SLL = 12'h008, SRL = 12'h004, SRA = 12'h002, LUI = 12'h001;

  typedef struct {
    logic [1:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        en;
    logic [3:0]  wen;
    logic        we;
    logic [4:0]  waddr;
    logic        selres;
    logic [31:0] r1;
    logic [31:0] r2;
  } pkt_t;

  function automatic logic [160:0] enc(input pkt_t p);
    return {p.mem_op, p.pc, p.inst, p.alu_op, p.s1, p.s2, p.en, p.wen,
            p.we, p.waddr, p.selres, p.r1, p.r2};
  endfunction

  function automatic logic [OBS_W-1:0] expect_of(input pkt_t p, input logic [31:0] res);
    logic [3:0] w;
    w = (p.en && p.wen != 4'b0) ? 4'b1111 : 4'b0000;
    return {p.mem_op, p.pc, p.en, p.wen, p.selres, p.we, p.waddr, res,
            p.we, p.waddr, res, p.selres & p.we, p.en, w, res, p.r2};
  endfunction

  function automatic pkt_t mk(input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] inst);
    pkt_t p;
    p = '{mem_op: 2'b00, pc: 32'hBFC00000, inst: inst, alu_op: op, s1: s1, s2: s2,
          en: 1'b0, wen: 4'b0, we: 1'b1, waddr: 5'd2, selres: 1'b0, r1: r1, r2: r2};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pkt_t p, input logic [31:0] res);
    id_to_ex_bus = enc(p);
    sb.push_back(expect_of(p, res));
  endtask

  task automatic test_reset();
    pkt_t p;
    p = mk(ADD, 3'b001, 4'b0001, 32'h1234, 32'h5678, 32'h0);
    p.en = 1'b1;
    p.selres = 1'b1;
    rst = 1'b1;
    stall = '0;
    id_to_ex_bus = enc(p);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs, e);
      end
    end
    rst = 1'b0;
    id_to_ex_bus = '0;
    sb.push_back('0);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_zero_bus got=%h want=%h", obs, e);
    end
  endtask

  task automatic test_addu();
    pkt_t p;
    p = mk(ADD, 3'b001, 4'b0001, 32'hFFFFFFFF, 32'd2, 32'h0);
    p.waddr = 5'd5;
    drive(p, 32'h00000001);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL addu got=%h want=%h", obs, e);
    end
    checks++;
    if (ex_to_rf_bus !== {1'b1, 5'd5, 32'h00000001}) begin
      errors++;
      $display("FAIL addu_rf got=%h want=%h", ex_to_rf_bus, {1'b1, 5'd5, 32'h00000001});
    end
  endtask

  task automatic test_sll_jal();
    pkt_t p;
    p = mk(SLL, 3'b100, 4'b0001, 32'h0, 32'h0000000F, 32'h00000100);
    drive(p, 32'h000000F0);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL sll got=%h want=%h", obs, e);
    end
    p = mk(ADD, 3'b010, 4'b0100, 32'h0, 32'h0, 32'h0C000000);
    p.pc = 32'hBFC00010;
    p.waddr = 5'd31;
    drive(p, 32'hBFC00018);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL jal got=%h want=%h", obs, e);
    end
  endtask

  task automatic test_alu_ops();
    pkt_t p[12];
    logic [31:0] r[12];
    p[0]  = mk(SUB,  3'b001, 4'b0001, 32'h0, 32'h1, 32'h0);                 r[0]  = 32'hFFFFFFFF;
    p[1]  = mk(SLT,  3'b001, 4'b0001, 32'hFFFFFFFF, 32'h1, 32'h0);          r[1]  = 32'h1;
    p[2]  = mk(SLTU, 3'b001, 4'b0001, 32'hFFFFFFFF, 32'h1, 32'h0);          r[2]  = 32'h0;
    p[3]  = mk(AND,  3'b001, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);   r[3]  = 32'hF000F000;
    p[4]  = mk(NOR,  3'b001, 4'b0001, 32'h0F0F0000, 32'h00FF00FF, 32'h0);   r[4]  = 32'hF000FF00;
    p[5]  = mk(OR,   3'b001, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);   r[5]  = 32'hFFF0FFF0;
    p[6]  = mk(XOR,  3'b001, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);   r[6]  = 32'h0FF00FF0;
    p[7]  = mk(SRL,  3'b100, 4'b0001, 32'h0, 32'h80000000, 32'h00000100);  r[7]  = 32'h08000000;
    p[8]  = mk(SRA,  3'b100, 4'b0001, 32'h0, 32'h80000000, 32'h00000100);  r[8]  = 32'hF8000000;
    p[9]  = mk(LUI,  3'b000, 4'b1000, 32'h0, 32'h0, 32'h3C011234);         r[9]  = 32'h12340000;
    p[10] = mk(12'h000, 3'b001, 4'b0001, 32'h5, 32'h7, 32'h0);             r[10] = 32'h0;
    p[11] = mk(ADD,  3'b000, 4'b0000, 32'h5, 32'h7, 32'h0);                r[11] = 32'h0;
    for (int i = 0; i < 12; i++) begin
      drive(p[i], r[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL alu_op[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_sw();
    pkt_t p;
    p = mk(ADD, 3'b001, 4'b0010, 32'h00001000, 32'hDEADBEEF, 32'hAC00FFFC);
    p.en = 1'b1;
    p.wen = 4'b0001;
    p.we = 1'b0;
    p.waddr = 5'd0;
    drive(p, 32'h00000FFC);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL sw got=%h want=%h", obs, e);
    end
    checks++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !==
        {1'b1, 4'b1111, 32'h00000FFC, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_sram got=%b %b %h %h", data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata);
    end
  endtask

  task automatic test_lw_hazard();
    pkt_t p;
    p = mk(ADD, 3'b001, 4'b0010, 32'h00002000, 32'h0, 32'h8C000008);
    p.mem_op = 2'b01;
    p.en = 1'b1;
    p.selres = 1'b1;
    p.waddr = 5'd8;
    drive(p, 32'h00002008);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL lw got=%h want=%h", obs, e);
    end
    checks++;
    if ({ex_load_hazard, data_sram_en, data_sram_wen} !== {1'b1, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL lw_hazard got=%b%b%b want=110000", ex_load_hazard, data_sram_en, data_sram_wen);
    end
    p = mk(ADD, 3'b001, 4'b0010, 32'h00000010, 32'h0, 32'h2408FFFF);
    p.waddr = 5'd9;
    drive(p, 32'h0000000F);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e || ex_load_hazard !== 1'b0) begin
      errors++;
      $display("FAIL addiu_after_lw got=%h want=%h", obs, e);
    end
  endtask

  task automatic test_stall_bubble();
    pkt_t a, b;
    logic [OBS_W-1:0] ea, eb;
    a = mk(ADD, 3'b001, 4'b0001, 32'h100, 32'h23, 32'h0);
    b = mk(XOR, 3'b001, 4'b0001, 32'hAAAA5555, 32'hFFFF0000, 32'h0);
    b.waddr = 5'd17;
    ea = expect_of(a, 32'h123);
    eb = expect_of(b, 32'h5555555);
    eb = expect_of(b, 32'h5555AAAA ^ 32'h0);
    eb = expect_of(b, 32'hAAAA5555 ^ 32'hFFFF0000);
    stall = '0;
    drive(a, 32'h123);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stall_load got=%h want=%h", obs, e);
    end
    stall = 6'b001100;
    id_to_ex_bus = enc(b);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ea);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hold[%0d] got=%h want=%h", i, obs, e);
      end
    end
    stall = 6'b000100;
    sb.push_back('0);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL bubble got=%h want=%h", obs, e);
    end
    stall = '0;
    sb.push_back(eb);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL after_bubble got=%h want=%h", obs, e);
    end
    stall = 6'b001000;
    drive(a, 32'h123);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ex_stall_only_loads got=%h want=%h", obs, e);
    end
    stall = 6'b001100;
    rst = 1'b1;
    sb.push_back('0);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_during_hold got=%h want=%h", obs, e);
    end
    rst = 1'b0;
    stall = '0;
  endtask

  task automatic test_reset_mid();
    pkt_t p;
    p = mk(ADD, 3'b001, 4'b0010, 32'h00003000, 32'hCAFEF00D, 32'hAC000004);
    p.en = 1'b1;
    p.wen = 4'b1111;
    p.we = 1'b0;
    drive(p, 32'h00003004);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL pre_reset_sw got=%h want=%h", obs, e);
    end
    rst = 1'b1;
    sb.push_back('0);
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e || data_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", obs, e);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = '0;
    id_to_ex_bus = '0;
    test_reset();
    test_addu();
    test_sll_jal();
    test_alu_ops();
    test_sw();
    test_lw_hazard();
    test_stall_bubble();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
